// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared types and constants for the mouse cursor tracker
//
// Holds the tracker FSM state enum, the bit positions inside the PS/2
// status byte, and the width of the sign-extended movement delta.

package mouse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      UPD_X,
      UPD_Y,
      PUBLISH
   } mouse_state_t;

   // Bit positions inside the PS/2 mouse status byte
   localparam int STAT_L    = 0;
   localparam int STAT_R    = 1;
   localparam int STAT_M    = 2;
   localparam int STAT_SYNC = 3;
   localparam int STAT_XS   = 4;
   localparam int STAT_YS   = 5;
   localparam int STAT_XV   = 6;
   localparam int STAT_YV   = 7;

   // Movement delta: sign bit from the status byte plus the 8-bit data byte
   localparam int DELTA_W = 9;

endpackage

// File: rtl/mouse_axis_clamp.sv
// rtl/mouse_axis_clamp.sv - signed add/subtract of one axis delta with clamp to screen
//
// Purpose: result = clamp(pos +/- delta, 0, limit), computed in POS_W+2
// signed bits so that neither the overshoot nor the undershoot can wrap.
// Ports:
//   pos    in  POS_W    current coordinate (unsigned)
//   delta  in  DELTA_W  two's-complement movement
//   sub    in  1        1: pos - delta, 0: pos + delta
//   limit  in  POS_W    largest legal coordinate
//   result out POS_W    clamped coordinate (combinational)

module mouse_axis_clamp
   import mouse_pkg::*;
#(
   parameter int POS_W = 10
) (
   input  logic [POS_W-1:0]   pos,
   input  logic [DELTA_W-1:0] delta,
   input  logic               sub,
   input  logic [POS_W-1:0]   limit,
   output logic [POS_W-1:0]   result
);

   localparam int SW = POS_W + 2;

   logic signed [SW-1:0] pos_s;
   logic signed [SW-1:0] delta_s;
   logic signed [SW-1:0] lim_s;
   logic signed [SW-1:0] sum;

   always_comb begin
      pos_s   = {2'b00, pos};
      delta_s = {{(SW-DELTA_W){delta[DELTA_W-1]}}, delta};
      lim_s   = {2'b00, limit};
      sum     = sub ? (pos_s - delta_s) : (pos_s + delta_s);
      if (sum[SW-1]) begin
         result = '0;
      end else if (sum > lim_s) begin
         result = limit;
      end else begin
         result = sum[POS_W-1:0];
      end
   end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// rtl/mouse_cursor_tracker.sv - applies PS/2 mouse packets to a clamped absolute cursor
//
// Purpose: accepts one {status, X, Y} packet per valid/ready handshake, checks
// it, adds the signed deltas to the cursor (Y inverted, screen grows down),
// clamps to the screen and publishes position and buttons with a one-cycle
// pos_valid strobe. Handshake at edge k -> pos_valid during cycle k+4, ready
// again in k+5; a dropped packet frees the block in k+2.
// Optional feature: MOUSE_PKT_CHECK_EN - drop packets whose status bit3 is 0.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pkt_valid/pkt_ready            packet handshake (ready is registered)
//   pkt_status, pkt_x, pkt_y       packet bytes
//   cursor_x, cursor_y             cursor position
//   btn_l, btn_r, btn_m            buttons from the last applied packet
//   pos_valid                      one-cycle update strobe
//   err_cnt                        saturating count of drops and overflowed axes

module mouse_cursor_tracker
   import mouse_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int POS_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pkt_valid,
   output logic             pkt_ready,
   input  logic [7:0]       pkt_status,
   input  logic [7:0]       pkt_x,
   input  logic [7:0]       pkt_y,
   output logic [POS_W-1:0] cursor_x,
   output logic [POS_W-1:0] cursor_y,
   output logic             btn_l,
   output logic             btn_r,
   output logic             btn_m,
   output logic             pos_valid,
   output logic [7:0]       err_cnt
);

   localparam logic [POS_W-1:0] X_MAX  = POS_W'(SCREEN_W - 1);
   localparam logic [POS_W-1:0] Y_MAX  = POS_W'(SCREEN_H - 1);
   localparam logic [POS_W-1:0] X_HOME = POS_W'(SCREEN_W / 2);
   localparam logic [POS_W-1:0] Y_HOME = POS_W'(SCREEN_H / 2);

   mouse_state_t state;

   logic [7:0]       status_q;
   logic [7:0]       x_q;
   logic [7:0]       y_q;
   logic [POS_W-1:0] work_x;
   logic             check_pass;

   logic [POS_W-1:0]   cl_pos;
   logic [DELTA_W-1:0] cl_delta;
   logic               cl_sub;
   logic [POS_W-1:0]   cl_limit;
   logic [POS_W-1:0]   cl_result;

`ifdef MOUSE_PKT_CHECK_EN
   assign check_pass = status_q[STAT_SYNC];
`else
   // Sync bit is deliberately ignored; CHECK still costs its cycle.
   assign check_pass = status_q[STAT_SYNC] | 1'b1;
`endif

   // One clamp unit shared by both axes; an overflowed axis moves by zero.
   always_comb begin
      if (state == UPD_Y) begin
         cl_pos   = cursor_y;
         cl_delta = status_q[STAT_YV] ? '0 : {status_q[STAT_YS], y_q};
         cl_sub   = 1'b1;
         cl_limit = Y_MAX;
      end else begin
         cl_pos   = cursor_x;
         cl_delta = status_q[STAT_XV] ? '0 : {status_q[STAT_XS], x_q};
         cl_sub   = 1'b0;
         cl_limit = X_MAX;
      end
   end

   mouse_axis_clamp #(
      .POS_W (POS_W)
   ) u_clamp (
      .pos    (cl_pos),
      .delta  (cl_delta),
      .sub    (cl_sub),
      .limit  (cl_limit),
      .result (cl_result)
   );

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pkt_ready <= 1'b1;
         status_q  <= '0;
         x_q       <= '0;
         y_q       <= '0;
         work_x    <= X_HOME;
         cursor_x  <= X_HOME;
         cursor_y  <= Y_HOME;
         btn_l     <= 1'b0;
         btn_r     <= 1'b0;
         btn_m     <= 1'b0;
         pos_valid <= 1'b0;
         err_cnt   <= '0;
      end else begin
         pos_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pkt_valid && pkt_ready) begin
                  status_q  <= pkt_status;
                  x_q       <= pkt_x;
                  y_q       <= pkt_y;
                  pkt_ready <= 1'b0;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (check_pass) begin
                  state <= UPD_X;
               end else begin
                  err_cnt   <= sat_inc(err_cnt);
                  pkt_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            UPD_X: begin
               work_x <= cl_result;
               if (status_q[STAT_XV]) begin
                  err_cnt <= sat_inc(err_cnt);
               end
               state <= UPD_Y;
            end
            UPD_Y: begin
               // Y result goes straight into cursor_y on this edge so the
               // whole new position is visible during the PUBLISH cycle.
               cursor_x  <= work_x;
               cursor_y  <= cl_result;
               btn_l     <= status_q[STAT_L];
               btn_r     <= status_q[STAT_R];
               btn_m     <= status_q[STAT_M];
               pos_valid <= 1'b1;
               if (status_q[STAT_YV]) begin
                  err_cnt <= sat_inc(err_cnt);
               end
               state <= PUBLISH;
            end
            PUBLISH: begin
               pkt_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               pkt_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb/tb_mouse_cursor_tracker.sv - table-driven self-checking bench for mouse_cursor_tracker

module tb_mouse_cursor_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] pkt_status = '0;
   logic [7:0] pkt_x = '0;
   logic [7:0] pkt_y = '0;
   logic       pkt_ready;
   logic [9:0] cursor_x;
   logic [9:0] cursor_y;
   logic       btn_l;
   logic       btn_r;
   logic       btn_m;
   logic       pos_valid;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   mouse_cursor_tracker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_status (pkt_status),
      .pkt_x      (pkt_x),
      .pkt_y      (pkt_y),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .btn_l      (btn_l),
      .btn_r      (btn_r),
      .btn_m      (btn_m),
      .pos_valid  (pos_valid),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] st;
      logic [7:0] x;
      logic [7:0] y;
      int         ex;
      int         ey;
      logic [2:0] eb;   // {m, r, l}
      int         ee;
   } vec_t;

   vec_t tbl [11];

   int         obs_lat;
   int         obs_hits;
   logic       obs_rdy1;
   logic       obs_rdy2;
   logic       obs_rdy5;
   logic [9:0] obs_x;
   logic [9:0] obs_y;
   logic [2:0] obs_btn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Sends one packet, then observes cycles k+1..k+8 after the handshake edge k.
   task automatic send_pkt(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      @(negedge clk);
      while (!pkt_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_send", {31'd0, pkt_ready}, 32'd1);
      pkt_status = st;
      pkt_x      = x;
      pkt_y      = y;
      pkt_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pkt_valid = 1'b0;
      obs_lat   = -1;
      obs_hits  = 0;
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 1) obs_rdy1 = pkt_ready;
         if (i == 2) obs_rdy2 = pkt_ready;
         if (i == 5) obs_rdy5 = pkt_ready;
         if (pos_valid) begin
            obs_hits++;
            if (obs_lat < 0) begin
               obs_lat = i;
               obs_x   = cursor_x;
               obs_y   = cursor_y;
               obs_btn = {btn_m, btn_r, btn_l};
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hits;

      // Cumulative from the reset position (320, 240)
      tbl[0]  = '{8'h09, 8'h05, 8'h03, 325, 237, 3'b001, 0};
      tbl[1]  = '{8'h38, 8'hFB, 8'hFE, 320, 239, 3'b000, 0};
      tbl[2]  = '{8'h08, 8'hFF, 8'hEA, 575,   5, 3'b000, 0};
      tbl[3]  = '{8'h08, 8'h19, 8'h00, 600,   5, 3'b000, 0};
      tbl[4]  = '{8'h08, 8'hFF, 8'hFF, 639,   0, 3'b000, 0};
      tbl[5]  = '{8'h08, 8'hFF, 8'hFF, 639,   0, 3'b000, 0};
      tbl[6]  = '{8'h08, 8'hFF, 8'hFF, 639,   0, 3'b000, 0};
      tbl[7]  = '{8'hC8, 8'h10, 8'h10, 639,   0, 3'b000, 2};
      tbl[8]  = '{8'h18, 8'h00, 8'h00, 383,   0, 3'b000, 2};
      tbl[9]  = '{8'h2B, 8'h01, 8'h00, 384, 256, 3'b011, 2};
      tbl[10] = '{8'h4C, 8'h55, 8'h01, 384, 255, 3'b100, 3};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cursor_x", 32'(cursor_x), 32'd320);
      check("rst_cursor_y", 32'(cursor_y), 32'd240);
      check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_pos_valid", {31'd0, pos_valid}, 32'd0);
      check("rst_buttons", {29'd0, btn_m, btn_r, btn_l}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         send_pkt(tbl[i].st, tbl[i].x, tbl[i].y);
         check($sformatf("v%0d_latency", i), 32'(obs_lat), 32'd4);
         check($sformatf("v%0d_strobe_len", i), 32'(obs_hits), 32'd1);
         check($sformatf("v%0d_busy_ready", i), {31'd0, obs_rdy1}, 32'd0);
         check($sformatf("v%0d_ready_k5", i), {31'd0, obs_rdy5}, 32'd1);
         check($sformatf("v%0d_cursor_x", i), 32'(obs_x), 32'(tbl[i].ex));
         check($sformatf("v%0d_cursor_y", i), 32'(obs_y), 32'(tbl[i].ey));
         check($sformatf("v%0d_buttons", i), 32'(obs_btn), 32'(tbl[i].eb));
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ee));
      end

      // Status byte with bit3 clear
      send_pkt(8'h00, 8'h05, 8'h05);
`ifdef MOUSE_PKT_CHECK_EN
      check("drop_no_strobe", 32'(obs_hits), 32'd0);
      check("drop_ready_k2", {31'd0, obs_rdy2}, 32'd1);
      check("drop_err_cnt", 32'(err_cnt), 32'd4);
      check("drop_cursor_x", 32'(cursor_x), 32'd384);
      check("drop_cursor_y", 32'(cursor_y), 32'd255);
`else
      check("nosync_latency", 32'(obs_lat), 32'd4);
      check("nosync_strobe_len", 32'(obs_hits), 32'd1);
      check("nosync_cursor_x", 32'(obs_x), 32'd389);
      check("nosync_cursor_y", 32'(obs_y), 32'd250);
      check("nosync_buttons", 32'(obs_btn), 32'd0);
      check("nosync_err_cnt", 32'(err_cnt), 32'd3);
`endif

      // Reset asserted while the packet sits in UPD_Y
      @(negedge clk);
      pkt_status = 8'h09;
      pkt_x      = 8'h10;
      pkt_y      = 8'h10;
      pkt_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pkt_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cursor_x", 32'(cursor_x), 32'd320);
      check("midrst_cursor_y", 32'(cursor_y), 32'd240);
      check("midrst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
      check("midrst_pos_valid", {31'd0, pos_valid}, 32'd0);
      check("midrst_err_cnt", 32'(err_cnt), 32'd0);
      check("midrst_buttons", {29'd0, btn_m, btn_r, btn_l}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (pos_valid) hits++;
      end
      check("midrst_no_strobe", 32'(hits), 32'd0);
      check("midrst_hold_x", 32'(cursor_x), 32'd320);

      // err_cnt saturation: 128 double-overflow packets is 256 increments
      for (int i = 0; i < 128; i++) begin
         send_pkt(8'hC8, 8'h7F, 8'h7F);
      end
      check("sat_err_cnt", 32'(err_cnt), 32'd255);
      check("sat_cursor_x", 32'(cursor_x), 32'd320);
      check("sat_cursor_y", 32'(cursor_y), 32'd240);
      send_pkt(8'hC8, 8'h01, 8'h01);
      check("sat_no_wrap", 32'(err_cnt), 32'd255);
      check("sat_strobe_len", 32'(obs_hits), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
